an_ord_gen: RTL and testbench

Synthesizable, parametrised generator for 1000BASE-X/SGMII auto-negotiation configuration ordered sets. It emits /C1/ /C2/ code groups with a latched 16-bit config word, optional automatic ACK insertion, and a trailing idle phase. It runs at code-group level (8-bit data + K flag, 125 MHz) and feeds the 8b/10b encoder/serialiser on the SGMII transmit path. It replaces fixed-count, fixed-config behavioural stimulus with a counted or continuous, abortable burst engine that can be used in RTL and in benches.

---
 rtl/an_ord_gen.sv | 209 ++++++++++++++++++++
 tb/tb_an_ord_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/an_ord_gen.sv
// Auto-negotiation configuration ordered-set generator (/C1/ /C2/ bursts, trailing idles)
// at code-group level for the 1000BASE-X / SGMII transmit path.
module an_ord_gen #(
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned IDLE_W    = 8,
  parameter int unsigned ACK_AFTER = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [COUNT_W-1:0] count,
  input  logic [IDLE_W-1:0]  idle_count,
  input  logic [15:0]        cfg,
  input  logic               ack_en,
  output logic [7:0]         tx_data,
  output logic               tx_k,
  output logic               tx_valid,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sets_sent
);

  localparam int unsigned GRP_W = 8;
  localparam logic [GRP_W-1:0] K28_5 = 8'hBC;
  localparam logic [GRP_W-1:0] D21_5 = 8'hB5;
  localparam logic [GRP_W-1:0] D2_2  = 8'h42;
  localparam logic [GRP_W-1:0] D5_6  = 8'hC5;
  localparam logic [GRP_W-1:0] D16_2 = 8'h50;

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_TAIL, S_DONE} state_t;

  state_t             state_q, state_n;
  logic [1:0]         pos_q, pos_n;       // group index within the set currently on the wire
  logic               phase_q, phase_n;   // 0 = /C1/, 1 = /C2/
  logic               ack_q, ack_n;
  logic               stop_q, stop_n;
  logic [15:0]        cfg_q, cfg_n;
  logic               ack_en_q, ack_en_n;
  logic [COUNT_W-1:0] count_q, count_n;
  logic [COUNT_W-1:0] sets_q, sets_n;
  logic [IDLE_W-1:0]  idle_q, idle_n;
  logic [IDLE_W-1:0]  tail_q, tail_n;
  logic               busy_n;
  logic               done_n;
  logic               k_n;
  logic [GRP_W-1:0]   data_n;
  logic               accept_c;
  logic               set_end_c;

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pos_q     <= 2'd1;
      phase_q   <= 1'b0;
      ack_q     <= 1'b0;
      stop_q    <= 1'b0;
      cfg_q     <= '0;
      ack_en_q  <= 1'b0;
      count_q   <= '0;
      sets_q    <= '0;
      idle_q    <= '0;
      tail_q    <= '0;
      tx_data   <= '0;
      tx_k      <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      pos_q     <= pos_n;
      phase_q   <= phase_n;
      ack_q     <= ack_n;
      stop_q    <= stop_n;
      cfg_q     <= cfg_n;
      ack_en_q  <= ack_en_n;
      count_q   <= count_n;
      sets_q    <= sets_n;
      idle_q    <= idle_n;
      tail_q    <= tail_n;
      tx_data   <= data_n;
      tx_k      <= k_n;
      tx_valid  <= 1'b1;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  assign sets_sent = sets_q;

  // Next-state, latching and next-output logic
  always_comb begin
    state_n   = state_q;
    pos_n     = pos_q;
    phase_n   = phase_q;
    ack_n     = ack_q;
    stop_n    = stop_q;
    cfg_n     = cfg_q;
    ack_en_n  = ack_en_q;
    count_n   = count_q;
    sets_n    = sets_q;
    idle_n    = idle_q;
    tail_n    = tail_q;
    busy_n    = busy;
    done_n    = 1'b0;
    k_n       = 1'b0;
    data_n    = '0;
    accept_c  = (state_q == S_IDLE) && !busy && start;
    set_end_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cfg_n    = cfg;
          ack_en_n = ack_en;
          count_n  = count;
          idle_n   = idle_count;
          sets_n   = '0;
          stop_n   = 1'b0;
          busy_n   = 1'b1;
        end else if (busy) begin
          stop_n = stop_q | stop;
        end
        // A pending burst enters CFG only on an idle-pair boundary
        if ((accept_c || busy) && (pos_q == 2'd1)) begin
          state_n = S_CFG;
          pos_n   = 2'd0;
          phase_n = 1'b0;
          ack_n   = cfg_n[14] | (ack_en_n && (32'(sets_n) >= 32'(ACK_AFTER)));
        end else begin
          pos_n = {1'b0, ~pos_q[0]};
        end
      end

      S_CFG: begin
        stop_n = stop_q | stop;
        if (pos_q == 2'd3) begin
          set_end_c = stop_q || stop || ((count_q != '0) && (sets_q >= count_q));
          pos_n     = 2'd0;
          if (set_end_c) begin
            if (idle_q == '0) begin
              state_n = S_DONE;
            end else begin
              state_n = S_TAIL;
              tail_n  = idle_q;
            end
          end else begin
            phase_n = ~phase_q;
            ack_n   = cfg_q[14] | (ack_en_q && (32'(sets_q) >= 32'(ACK_AFTER)));
          end
        end else begin
          pos_n = 2'(pos_q + 2'd1);
          if (pos_n == 2'd3 && sets_q != '1) begin
            sets_n = sets_q + COUNT_W'(1);
          end
        end
      end

      S_TAIL: begin
        if (pos_q == 2'd0) begin
          pos_n = 2'd1;
        end else if (tail_q == IDLE_W'(1)) begin
          state_n = S_DONE;
          pos_n   = 2'd0;
        end else begin
          pos_n  = 2'd0;
          tail_n = tail_q - IDLE_W'(1);
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        pos_n   = 2'd1;
      end

      default: begin
        state_n = S_IDLE;
        pos_n   = 2'd1;
      end
    endcase

    if (state_n == S_DONE) begin
      busy_n = 1'b0;
      done_n = 1'b1;
    end

    // Group that will be on the wire next cycle
    k_n = (pos_n == 2'd0);
    case (state_n)
      S_CFG: begin
        case (pos_n)
          2'd0:    data_n = K28_5;
          2'd1:    data_n = phase_n ? D2_2 : D21_5;
          2'd2:    data_n = cfg_n[7:0];
          default: data_n = {cfg_n[15], ack_n, cfg_n[13:8]};
        endcase
      end
      S_TAIL: begin
        if (pos_n == 2'd0) data_n = K28_5;
        else               data_n = (tail_n == idle_n) ? D5_6 : D16_2;
      end
      default: begin
        data_n = (pos_n == 2'd0) ? K28_5 : D16_2;
      end
    endcase
  end

endmodule

// File: tb/tb_an_ord_gen.sv
// Directed bench for an_ord_gen: expected code-group streams are hand-written per scenario.
module tb_an_ord_gen;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [7:0]  count;
  logic [7:0]  idle_count;
  logic [15:0] cfg;
  logic        ack_en;
  logic [7:0]  tx_data;
  logic        tx_k;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic [7:0]  sets_sent;

  int n_vec;
  int n_err;

  an_ord_gen #(.COUNT_W(8), .IDLE_W(8), .ACK_AFTER(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .idle_count (idle_count),
    .cfg        (cfg),
    .ack_en     (ack_en),
    .tx_data    (tx_data),
    .tx_k       (tx_k),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .done       (done),
    .sets_sent  (sets_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check {done, valid, k, data} of the current cycle, then advance one cycle
  task automatic step(input string tag, input logic k, input logic [7:0] d, input logic dn);
    chk(tag, 32'({done, tx_valid, tx_k, tx_data}), 32'({dn, 1'b1, k, d}));
    tick();
  endtask

  task automatic cfg_set(input string tag, input logic c2, input logic [7:0] lo, input logic [7:0] hi);
    step(tag, 1'b1, 8'hBC, 1'b0);
    step(tag, 1'b0, c2 ? 8'h42 : 8'hB5, 1'b0);
    step(tag, 1'b0, lo, 1'b0);
    step(tag, 1'b0, hi, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    count = '0;
    idle_count = '0;
    cfg = '0;
    ack_en = 1'b0;
    tick();
    tick();
    chk("reset_out", 32'({tx_valid, tx_k, tx_data}), 32'h0);
    chk("reset_stat", 32'({busy, done, sets_sent}), 32'h0);

    // Reset release then /I2/ stream
    reset_n = 1'b1;
    tick();
    step("idle0", 1'b1, 8'hBC, 1'b0);
    step("idle1", 1'b0, 8'h50, 1'b0);
    chk("idle_busy", 32'(busy), 32'h0);
    step("idle2", 1'b1, 8'hBC, 1'b0);

    // Counted burst, start on second group of pair -> /C1/ next cycle
    cfg = 16'h0001; count = 8'd2; idle_count = 8'd1; ack_en = 1'b0; start = 1'b1;
    step("cnt_pre", 1'b0, 8'h50, 1'b0);
    start = 1'b0;
    chk("cnt_busy", 32'(busy), 32'h1);
    cfg_set("cnt_s0", 1'b0, 8'h01, 8'h00);
    cfg_set("cnt_s1", 1'b1, 8'h01, 8'h00);
    step("cnt_i1a", 1'b1, 8'hBC, 1'b0);
    step("cnt_i1b", 1'b0, 8'hC5, 1'b0);
    chk("cnt_sets", 32'(sets_sent), 32'd2);
    chk("cnt_busy_done", 32'(busy), 32'h0);
    step("cnt_done", 1'b1, 8'hBC, 1'b1);
    step("cnt_post", 1'b0, 8'h50, 1'b0);

    // ACK insertion; start on first group -> /C1/ two cycles later; re-start while busy ignored
    cfg = 16'h0001; count = 8'd5; idle_count = 8'd0; ack_en = 1'b1; start = 1'b1;
    step("ack_pre0", 1'b1, 8'hBC, 1'b0);
    chk("ack_busy", 32'(busy), 32'h1);
    cfg = 16'hFFFF; count = 8'd1; ack_en = 1'b0;
    step("ack_pre1", 1'b0, 8'h50, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b0;
      cfg_set($sformatf("ack_s%0d", i), 1'(i % 2), 8'h01, (i >= 3) ? 8'h40 : 8'h00);
    end
    chk("ack_sets", 32'(sets_sent), 32'd5);
    step("ack_done", 1'b1, 8'hBC, 1'b1);

    // start+stop together in IDLE: stop ignored, full burst
    cfg = 16'hA5C3; count = 8'd3; idle_count = 8'd2; ack_en = 1'b0; start = 1'b1; stop = 1'b1;
    step("ss_pre", 1'b0, 8'h50, 1'b0);
    start = 1'b0; stop = 1'b0;
    cfg_set("ss_s0", 1'b0, 8'hC3, 8'hA5);
    cfg_set("ss_s1", 1'b1, 8'hC3, 8'hA5);
    cfg_set("ss_s2", 1'b0, 8'hC3, 8'hA5);
    step("ss_t0a", 1'b1, 8'hBC, 1'b0);
    step("ss_t0b", 1'b0, 8'hC5, 1'b0);
    step("ss_t1a", 1'b1, 8'hBC, 1'b0);
    step("ss_t1b", 1'b0, 8'h50, 1'b0);
    chk("ss_sets", 32'(sets_sent), 32'd3);
    step("ss_done", 1'b1, 8'hBC, 1'b1);

    // Continuous burst, stop during group 2 of set 6
    cfg = 16'h1234; count = 8'd0; idle_count = 8'd1; start = 1'b1;
    step("cont_pre", 1'b0, 8'h50, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 6; i++) cfg_set($sformatf("cont_s%0d", i), 1'(i % 2), 8'h34, 8'h12);
    step("cont_s6a", 1'b1, 8'hBC, 1'b0);
    step("cont_s6b", 1'b0, 8'hB5, 1'b0);
    stop = 1'b1;
    step("cont_s6c", 1'b0, 8'h34, 1'b0);
    stop = 1'b0;
    step("cont_s6d", 1'b0, 8'h12, 1'b0);
    step("cont_ia", 1'b1, 8'hBC, 1'b0);
    step("cont_ib", 1'b0, 8'hC5, 1'b0);
    chk("cont_sets", 32'(sets_sent), 32'd7);
    step("cont_done", 1'b1, 8'hBC, 1'b1);

    // Reset during set 1, byte 2
    cfg = 16'h0001; count = 8'd0; idle_count = 8'd1; start = 1'b1;
    step("rst_pre", 1'b0, 8'h50, 1'b0);
    start = 1'b0;
    cfg_set("rst_s0", 1'b0, 8'h01, 8'h00);
    step("rst_s1a", 1'b1, 8'hBC, 1'b0);
    step("rst_s1b", 1'b0, 8'h42, 1'b0);
    chk("rst_pre_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_out", 32'({tx_valid, tx_k, tx_data}), 32'h0);
    chk("rst_async_stat", 32'({busy, done, sets_sent}), 32'h0);
    #1;
    reset_n = 1'b1;
    tick();
    step("rst_i0", 1'b1, 8'hBC, 1'b0);
    step("rst_i1", 1'b0, 8'h50, 1'b0);
    step("rst_i2", 1'b1, 8'hBC, 1'b0);
    chk("rst_busy", 32'(busy), 32'h0);
    step("rst_i3", 1'b0, 8'h50, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
